// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control and status bundle for pc_sequencer
// Purpose: groups the next-PC control inputs and the pc / return-address-stack
//          status outputs of pc_sequencer.
// Ports (slave view):
//   in : stall, branch_taken, branch_off[OFF_W], jump, jtarget[26], call,
//        jr, jr_addr[PC_W], ret
//   out: pc[PC_W], ras_count[5], ras_empty, ras_full, ras_err
interface pc_sequencer_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned OFF_W = 16
);
  logic             stall;
  logic             branch_taken;
  logic [OFF_W-1:0] branch_off;
  logic             jump;
  logic [25:0]      jtarget;
  logic             call;
  logic             jr;
  logic [PC_W-1:0]  jr_addr;
  logic             ret;
  logic [PC_W-1:0]  pc;
  logic [4:0]       ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;

  modport master (
    output stall, branch_taken, branch_off, jump, jtarget, call, jr, jr_addr, ret,
    input  pc, ras_count, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, branch_taken, branch_off, jump, jtarget, call, jr, jr_addr, ret,
    output pc, ras_count, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with optional return-address stack
// Purpose: registered next-PC selection with priority
//          stall > ret > jr > jump > branch_taken > pc+1, all arithmetic wrapping.
//          jump+call pushes pc+1 onto a circular return-address stack that ret pops.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (0 = in reset)
//   bus   - pc_sequencer_if.slave: control inputs, pc and RAS status outputs
// Config: define PC_SEQUENCER_RAS_EN to build the return-address stack. Without it
//         ret and call are ignored and ras_count=0, ras_empty=1, ras_full=0, ras_err=0.
module pc_sequencer #(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     OFF_W     = 16,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  logic [PC_W-1:0]        pc_q;
  logic [PC_W-1:0]        pc_nxt;
  logic [PC_W-1:0]        pc_inc;
  logic [PC_W-1:0]        br_tgt;
  logic [PC_W-1:0]        jmp_tgt;
  logic signed [PC_W-1:0] off_ext;

  assign pc_inc  = pc_q + PC_W'(1);
  // Size cast of a signed operand sign-extends; also covers OFF_W == PC_W.
  assign off_ext = PC_W'($signed(bus.branch_off));
  assign br_tgt  = pc_inc + off_ext;
  // Jump keeps the region bits of the incremented PC.
  assign jmp_tgt = {pc_inc[PC_W-1:26], bus.jtarget};

`ifdef PC_SEQUENCER_RAS_EN
  localparam int unsigned AW     = $clog2(RAS_DEPTH);
  localparam logic [4:0]  DEPTH5 = 5'(RAS_DEPTH);

  logic [PC_W-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]   wp;        // next slot to write; top of stack sits at wp-1
  logic [4:0]      cnt;
  logic            err;
  logic            push;
  logic            pop;
  logic            err_set;
  logic [PC_W-1:0] ras_top;

  assign ras_top = ras_mem[wp - AW'(1)];
`endif

  always_comb begin
    pc_nxt = pc_inc;
`ifdef PC_SEQUENCER_RAS_EN
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
`endif
    if (bus.stall) begin
      pc_nxt = pc_q;
    end
`ifdef PC_SEQUENCER_RAS_EN
    else if (bus.ret) begin
      // Empty-stack return falls through to pc+1 and flags underflow.
      if (cnt != 5'd0) begin
        pc_nxt = ras_top;
        pop    = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end
`endif
    else if (bus.jr) begin
      pc_nxt = bus.jr_addr;
    end else if (bus.jump) begin
      pc_nxt = jmp_tgt;
`ifdef PC_SEQUENCER_RAS_EN
      push = bus.call;
`endif
    end else if (bus.branch_taken) begin
      pc_nxt = br_tgt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_nxt;
    end
  end

  assign bus.pc = pc_q;

`ifdef PC_SEQUENCER_RAS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      cnt <= 5'd0;
      err <= 1'b0;
    end else begin
      if (push) begin
        // A full stack wraps over its oldest entry; depth stays saturated.
        wp <= wp + AW'(1);
        if (cnt == DEPTH5) begin
          err <= 1'b1;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end else if (pop) begin
        wp  <= wp - AW'(1);
        cnt <= cnt - 5'd1;
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  // Storage is not reset; entries are unreachable while cnt == 0.
  always_ff @(posedge clk) begin
    if (push && reset) begin
      ras_mem[wp] <= pc_inc;
    end
  end

  assign bus.ras_count = cnt;
  assign bus.ras_empty = (cnt == 5'd0);
  assign bus.ras_full  = (cnt == DEPTH5);
  assign bus.ras_err   = err;
`else
  logic unused_ras;
  assign unused_ras = &{1'b0, bus.call, bus.ret};

  assign bus.ras_count = 5'd0;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_err   = 1'b0;
`endif

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 32, PC width in words (word-addressed), legal range 27..64.
REQ-002 Parameter OFF_W, default 16, signed branch-offset width, legal range 2..PC_W.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries, power of two, 2..16.
REQ-004 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-007 stall  in  1  hold PC and RAS this cycle.
REQ-008 branch_taken  in  1  conditional branch resolved taken.
REQ-009 branch_off  in  OFF_W  signed word offset relative to pc+1.
REQ-010 jump  in  1  absolute jump.
REQ-011 jtarget  in  26  jump target field.
REQ-012 call  in  1  qualifies jump as call (push return address).
REQ-013 jr  in  1  jump-register.
REQ-014 jr_addr  in  PC_W  jump-register target.
REQ-015 ret  in  1  return, pop RAS.
REQ-016 pc  out  PC_W  current program counter (registered).
REQ-017 ras_count  out  5  valid RAS entries, 0..RAS_DEPTH.
REQ-018 ras_empty  out  1  ras_count == 0.
REQ-019 ras_full  out  1  ras_count == RAS_DEPTH.
REQ-020 ras_err  out  1  sticky: RAS underflow or overflow occurred.

Function
REQ-021 pc_inc SHALL equal pc+1 modulo 2^PC_W; all PC arithmetic wraps silently.
REQ-022 Next-PC priority SHALL be: stall > ret > jr > jump > branch_taken > sequential.
REQ-023 stall=1: pc, RAS contents, ras_count and ras_err SHALL hold; all other inputs ignored.
REQ-024 ret with ras_count>0: pc <= top entry, ras_count decrements, one-cycle latency.
REQ-025 ret with ras_count==0: pc <= pc_inc, ras_err <= 1.
REQ-026 jr: pc <= jr_addr.
REQ-027 jump: pc <= {pc_inc[PC_W-1:26], jtarget}.
REQ-028 jump with call: additionally push pc_inc onto RAS in the same cycle.
REQ-029 Push with ras_count==RAS_DEPTH: oldest entry SHALL be overwritten (circular), ras_count stays RAS_DEPTH, ras_err <= 1.
REQ-030 call without jump, or call while a higher-priority ret/jr is asserted, SHALL be ignored (no push).
REQ-031 branch_taken: pc <= pc_inc + sign_extend(branch_off).
REQ-032 No control input asserted: pc <= pc_inc.
REQ-033 ras_empty, ras_full SHALL be combinational decodes of registered ras_count.
REQ-034 ras_err SHALL clear only on reset.

Reset
REQ-035 reset=0 SHALL asynchronously force pc=RESET_PC, ras_count=0, ras_err=0, independent of clk.
REQ-036 RAS entry storage need not be cleared; entries are unreadable while ras_count==0.
REQ-037 Reset asserted mid-operation SHALL abort any push/pop; first update after deassertion uses sequential rules from RESET_PC.

Configuration
REQ-038 Macro PC_SEQUENCER_RAS_EN defined: RAS fully implemented per REQ-024..REQ-030.
REQ-039 Macro PC_SEQUENCER_RAS_EN undefined: no RAS storage; ret treated as no-op (falls to next priority), call ignored, ras_count=0, ras_empty=1, ras_full=0, ras_err=0 constantly.

Verification
REQ-040 Reset pulse mid-run (pc=0x37) with RESET_PC=0x100 -> pc=0x100 immediately, then 0x101, 0x102 on following edges.
REQ-041 pc=0x10, branch_taken, branch_off=-4 -> pc=0x0D; branch_off=+3 from pc=0xFFFFFFFF -> pc=0x3 (wrap).
REQ-042 pc=0x10, jump+call, jtarget=0x200 -> pc=0x200, ras_count=1; then ret -> pc=0x11, ras_count=0, ras_err=0.
REQ-043 RAS_DEPTH=4: five nested calls -> ras_full=1, ras_err=1, count=4; five rets -> first four return newest-to-oldest minus oldest, fifth gives pc_inc.
REQ-044 Simultaneous ret, jr, jump, branch_taken with stall=1 -> pc unchanged; stall=0 -> ret taken, no push.
REQ-045 Build without PC_SEQUENCER_RAS_EN: jump+call then ret -> pc goes to target, then pc_inc; ras_empty stays 1.
